// File: rtl/uart_rx_if.sv
// Parallel-side and serial-side signal bundle for the UART receiver.
// The master drives the line and the frame config. The slave is the receiver.
interface uart_rx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             RX_IN;
  logic [5:0]       Prescale;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic [WIDTH-1:0] P_DATA;
  logic             Data_Valid;
  logic             Parity_Error;
  logic             Stop_Error;
  logic             RX_Busy;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, Data_Valid, Parity_Error, Stop_Error, RX_Busy
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, Data_Valid, Parity_Error, Stop_Error, RX_Busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 3-sample majority vote per bit, LSB-first data,
// optional parity, one stop bit, single-cycle result pulses.
module uart_rx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  uart_rx_if.slave   bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e           state_q, state_d;
  logic [5:0]       edge_q, edge_d;
  logic [CntW-1:0]  bit_q, bit_d;
  logic [2:0]       samp_q, samp_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [5:0]       prescale_q, prescale_d;
  logic             par_en_q, par_en_d;
  logic             par_typ_q, par_typ_d;
  logic             par_err_q, par_err_d;
  logic             stop_err_q, stop_err_d;
  logic [WIDTH-1:0] p_data_q, p_data_d;
  logic             dv_q, dv_d;
  logic             pe_q, pe_d;
  logic             se_q, se_d;

  logic [5:0] half;
  logic       bit_end;
  logic       maj;

  assign half    = {1'b0, prescale_q[5:1]};
  assign bit_end = (edge_q == prescale_q - 6'd1);
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    if (state_q == StIdle) begin
      edge_d = 6'd0;
      // The start-detect cycle itself is edge_cnt 0 of the start bit.
      if (!bus.RX_IN) begin
        state_d    = StStart;
        edge_d     = 6'd1;
        bit_d      = '0;
        prescale_d = bus.Prescale;
        par_en_d   = bus.PAR_EN;
        par_typ_d  = bus.PAR_TYP;
        par_err_d  = 1'b0;
        stop_err_d = 1'b0;
      end
    end else begin
      edge_d = bit_end ? 6'd0 : edge_q + 6'd1;
      if (edge_q == half - 6'd1) samp_d[0] = bus.RX_IN;
      if (edge_q == half)        samp_d[1] = bus.RX_IN;
      if (edge_q == half + 6'd1) samp_d[2] = bus.RX_IN;

      unique case (state_q)
        StStart: begin
          if (bit_end) state_d = maj ? StIdle : StData;
        end
        StData: begin
          if (bit_end) begin
            shift_d = {maj, shift_q[WIDTH-1:1]};
            bit_d   = bit_q + CntW'(1);
            if (bit_q == CntW'(WIDTH - 1)) state_d = par_en_q ? StParity : StStop;
          end
        end
        StParity: begin
          if (bit_end) begin
            if (maj != ((^shift_q) ^ par_typ_q)) par_err_d = 1'b1;
            state_d = StStop;
          end
        end
        StStop: begin
          if (bit_end) begin
            state_d    = StIdle;
            stop_err_d = stop_err_q | ~maj;
            pe_d       = par_err_q;
            se_d       = stop_err_q | ~maj;
            if (!par_err_q && !stop_err_q && maj) begin
              p_data_d = shift_q;
              dv_d     = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      edge_q     <= '0;
      bit_q      <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign bus.P_DATA       = p_data_q;
  assign bus.Data_Valid   = dv_q;
  assign bus.Parity_Error = pe_q;
  assign bus.Stop_Error   = se_q;
  // A low line seen in IDLE is the start-detect cycle, which already belongs to the frame.
  assign bus.RX_Busy      = (state_q != StIdle) | ~bus.RX_IN;
endmodule
